// File: rtl/cic_decimator_comb.sv
// cic_decimator_comb: decimates the integrator-chain output by RATE, then runs
// STAGES pipelined comb sections with differential delay DIFF_DELAY.
module cic_decimator_comb #(
    parameter int DATA_WIDTH_INP = 32,
    parameter int DATA_WIDTH_OUT = 16,
    parameter int RATE           = 8,
    parameter int STAGES         = 3,
    parameter int DIFF_DELAY     = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [DATA_WIDTH_INP-1:0] inp_samp_data,
    input  logic                      inp_samp_str,
    output logic [DATA_WIDTH_OUT-1:0] out_samp_data,
    output logic                      out_samp_str
);
    localparam int W  = DATA_WIDTH_INP;
    localparam int CW = RATE > 1 ? $clog2(RATE) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  dec_q, dec_d;
    logic          dec_str_q, dec_str_d;
    logic          cap;

    // Index 0 is the decimated sample; index k is the output of comb section k.
    logic [STAGES:0][W-1:0] stage_data;
    logic [STAGES:0]        stage_str;

    always_comb begin
        cap       = inp_samp_str && cnt_q == CW'(RATE - 1);
        cnt_d     = cap ? '0 : cnt_q + CW'(inp_samp_str);
        dec_d     = cap ? inp_samp_data : dec_q;
        dec_str_d = cap;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            dec_q     <= '0;
            dec_str_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dec_q     <= dec_d;
            dec_str_q <= dec_str_d;
        end
    end

    assign stage_data[0] = dec_q;
    assign stage_str[0]  = dec_str_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_comb
        logic [W-1:0] y_q, y_d, d0_q, d0_d, d1_q, d1_d;
        logic         str_q, str_d;

        // d1 only feeds the subtractor when the differential delay is 2.
        always_comb begin
            str_d = stage_str[k];
            y_d   = stage_str[k] ? stage_data[k] - (DIFF_DELAY == 2 ? d1_q : d0_q) : y_q;
            d0_d  = stage_str[k] ? stage_data[k] : d0_q;
            d1_d  = stage_str[k] ? d0_q : d1_q;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                y_q   <= '0;
                d0_q  <= '0;
                d1_q  <= '0;
                str_q <= 1'b0;
            end else begin
                y_q   <= y_d;
                d0_q  <= d0_d;
                d1_q  <= d1_d;
                str_q <= str_d;
            end
        end

        assign stage_data[k+1] = y_q;
        assign stage_str[k+1]  = str_q;
    end

    assign out_samp_data = DATA_WIDTH_OUT'(stage_data[STAGES] >> (W - DATA_WIDTH_OUT));
    assign out_samp_str  = stage_str[STAGES];
endmodule

// File: tb/tb_cic_decimator_comb.sv
// tb_cic_decimator_comb: vector tables, directed corner sequences and a randomized
// run of the default configuration against a binomial-sum reference model.
module tb_cic_decimator_comb;
    localparam int AR = 8, AN = 3, AM = 1;

    typedef struct { int u; logic [31:0] din; logic [31:0] exp; } vec_t;
    typedef struct { logic [15:0] v; int t; } exp_t;

    logic clk = 1'b0, reset_n = 1'b0;
    logic [31:0] a_d = '0, b_d = '0, c_d = '0, e_d = '0, f_d = '0;
    logic [31:0] b_o, c_o, e_o, f_o;
    logic [7:0]  d_d = '0, d_o;
    logic [15:0] a_o;
    logic a_s = 1'b0, b_s = 1'b0, c_s = 1'b0, d_s = 1'b0, e_s = 1'b0, f_s = 1'b0;
    logic a_os, b_os, c_os, d_os, e_os, f_os;

    int n_vec = 0, n_bad = 0, mcyc = 0, a_cnt = 0;
    logic [31:0] a_hist[$], b_q[$], e_val[$];
    int e_in[$], e_out[$];
    exp_t a_exp[$], a_e;
    vec_t tbl[11];
    logic [31:0] ev[5];

    always #5 clk = ~clk;

    cic_decimator_comb u_a (.clk(clk), .reset_n(reset_n), .inp_samp_data(a_d), .inp_samp_str(a_s),
                            .out_samp_data(a_o), .out_samp_str(a_os));
    cic_decimator_comb #(.DATA_WIDTH_OUT(32), .RATE(4), .STAGES(1)) u_b (.clk(clk), .reset_n(reset_n),
                            .inp_samp_data(b_d), .inp_samp_str(b_s), .out_samp_data(b_o), .out_samp_str(b_os));
    cic_decimator_comb #(.DATA_WIDTH_OUT(32), .RATE(1), .STAGES(3)) u_c (.clk(clk), .reset_n(reset_n),
                            .inp_samp_data(c_d), .inp_samp_str(c_s), .out_samp_data(c_o), .out_samp_str(c_os));
    cic_decimator_comb #(.DATA_WIDTH_INP(8), .DATA_WIDTH_OUT(8), .RATE(1), .STAGES(1)) u_d (.clk(clk),
                            .reset_n(reset_n), .inp_samp_data(d_d), .inp_samp_str(d_s), .out_samp_data(d_o),
                            .out_samp_str(d_os));
    cic_decimator_comb #(.DATA_WIDTH_OUT(32), .RATE(4), .STAGES(3)) u_e (.clk(clk), .reset_n(reset_n),
                            .inp_samp_data(e_d), .inp_samp_str(e_s), .out_samp_data(e_o), .out_samp_str(e_os));
    cic_decimator_comb #(.DATA_WIDTH_OUT(32), .RATE(1), .STAGES(1), .DIFF_DELAY(2)) u_f (.clk(clk),
                            .reset_n(reset_n), .inp_samp_data(f_d), .inp_samp_str(f_s), .out_samp_data(f_o),
                            .out_samp_str(f_os));

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", nm, $signed(act), act, $signed(exp), exp);
        end
    endtask

    // N-stage comb of the decimated stream as a binomial sum: y[n] = sum (-1)^j C(N,j) x[n-jM].
    function automatic logic [15:0] ref_out();
        logic [31:0] acc, x;
        int c;
        acc = '0;
        c = 1;
        for (int j = 0; j <= AN; j++) begin
            x = (j * AM < a_hist.size()) ? a_hist[j*AM] : '0;
            acc = (j % 2 == 1) ? acc - 32'(c) * x : acc + 32'(c) * x;
            c = c * (AN - j) / (j + 1);
        end
        return acc[31:16];
    endfunction

    always @(negedge clk) begin
        mcyc++;
        if (!reset_n) begin
            a_cnt = 0;
            a_hist.delete();
            a_exp.delete();
        end else if (a_s) begin
            a_cnt++;
            if (a_cnt % AR == 0) begin
                a_hist.push_front(a_d);
                a_exp.push_back('{ref_out(), mcyc + AN + 1});
            end
        end
        if (a_os) begin
            if (a_exp.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL rand_extra: unexpected out_samp_str with data 0x%h, expected none", a_o);
            end else begin
                a_e = a_exp.pop_front();
                chk("rand_data", 32'(a_o), 32'(a_e.v));
                chk("rand_time", mcyc, a_e.t);
            end
        end
        if (b_os) b_q.push_back(b_o);
        if (e_s) e_in.push_back(mcyc);
        if (e_os) begin
            e_out.push_back(mcyc);
            e_val.push_back(e_o);
        end
    end

    task automatic pulse(int u, logic [31:0] x);
        case (u)
            0: begin a_d = x; a_s = 1'b1; end
            1: begin b_d = x; b_s = 1'b1; end
            2: begin c_d = x; c_s = 1'b1; end
            3: begin d_d = x[7:0]; d_s = 1'b1; end
            4: begin e_d = x; e_s = 1'b1; end
            default: begin f_d = x; f_s = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        {a_s, b_s, c_s, d_s, e_s, f_s} = '0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic peek(int u, output logic s, output logic [31:0] v);
        case (u)
            2: begin s = c_os; v = c_o; end
            3: begin s = d_os; v = {{24{d_o[7]}}, d_o}; end
            default: begin s = f_os; v = f_o; end
        endcase
    endtask

    initial begin
        logic got;
        logic [31:0] v;
        tbl = '{'{2, 7, 7}, '{2, 7, -14}, '{2, 7, 7}, '{2, 7, 0}, '{2, 7, 0},
                '{3, 120, 120}, '{3, -126, 10},
                '{5, 10, 10}, '{5, 20, 20}, '{5, 30, 20}, '{5, 40, 20}};
        ev = '{4, -4, 0, 0, 0};

        idle(3);
        chk("rst_a_data", 32'(a_o), 0);
        chk("rst_a_str", 32'(a_os), 0);
        chk("rst_b_data", b_o, 0);
        chk("rst_c_data", c_o, 0);
        chk("rst_d_data", 32'(d_o), 0);
        chk("rst_e_str", 32'(e_os), 0);
        chk("rst_f_data", f_o, 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            pulse(tbl[i].u, tbl[i].din);
            got = 1'b0;
            v = '0;
            for (int j = 0; j < 8 && !got; j++) begin
                @(negedge clk);
                peek(tbl[i].u, got, v);
            end
            if (!got) begin
                n_vec++;
                n_bad++;
                $display("FAIL vec%0d_timeout: no out_samp_str within 8 cycles, expected data %0d", i,
                         $signed(tbl[i].exp));
            end else chk($sformatf("vec%0d", i), v, tbl[i].exp);
            @(posedge clk);
            #1;
        end

        b_q.delete();
        for (int k = 1; k <= 12; k++) pulse(1, 32'(5 * k));
        idle(4);
        chk("ramp_count", b_q.size(), 3);
        foreach (b_q[i]) chk($sformatf("ramp%0d", i), b_q[i], 20);

        for (int r = 0; r < 2; r++) begin
            e_in.delete();
            e_out.delete();
            e_val.delete();
            for (int i = 1; i <= 20; i++) begin
                pulse(4, 32'(i));
                if (r == 0) idle(2);
            end
            idle(8);
            chk($sformatf("strobe_count_r%0d", r), e_out.size(), 5);
            foreach (e_out[i])
                chk($sformatf("strobe_lat_r%0d_%0d", r, i), e_out[i],
                    (4 * i + 3 < e_in.size()) ? e_in[4*i+3] + 4 : -1);
            if (r == 0)
                foreach (e_val[i]) chk($sformatf("ramp3_%0d", i), e_val[i], i < 5 ? ev[i] : 32'hDEAD_BEEF);
        end

        b_q.delete();
        pulse(1, 5);
        pulse(1, 10);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_data", b_o, 0);
        chk("midrst_str", 32'(b_os), 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 3; k++) pulse(1, 32'(100 * k));
        idle(4);
        chk("midrst_early", b_q.size(), 0);
        pulse(1, 400);
        idle(4);
        chk("midrst_count", b_q.size(), 1);
        chk("midrst_first", b_q.size() > 0 ? b_q[0] : 32'hDEAD_BEEF, 400);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) != 0)
                pulse(0, $urandom_range(7) == 0 ? 32'h8000_0000 : $urandom);
            else
                idle(1);
        end
        idle(8);
        chk("rand_pending", a_exp.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/cic_decimator_comb.md
Name: cic_decimator_comb

Overview:
- Downstream neighbour of the CIC integrator chain. Takes the last integrator's output and strobe, decimates by RATE, then runs STAGES pipelined comb sections with differential delay DIFF_DELAY.
- Produces the CIC decimator output sample and its one-cycle strobe.
- Arithmetic is modular two's complement, so integrator wrap-around cancels exactly.

Parameters:
- DATA_WIDTH_INP, 32: input and internal comb width, signed.
- DATA_WIDTH_OUT, 16: output width, signed. Must satisfy DATA_WIDTH_OUT <= DATA_WIDTH_INP.
- RATE, 8: decimation factor R, >= 1.
- STAGES, 3: number of comb sections N, >= 1.
- DIFF_DELAY, 1: differential delay M per comb, 1 or 2.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- inp_samp_data  in  DATA_WIDTH_INP  signed sample from integrator chain
- inp_samp_str  in  1  input sample valid, one-cycle pulse per sample
- out_samp_data  out  DATA_WIDTH_OUT  signed decimated, combed sample
- out_samp_str  out  1  output sample valid, one-cycle pulse

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. Reset clears all of the following to 0:
  - decimation counter
  - decimated register and its strobe
  - all comb registers, delay lines and stage strobes
  - out_samp_data = 0, out_samp_str = 0
- Reset mid-operation: the partial decimation count is discarded. After release, capture restarts at the RATE-th strobe.
- Decimation counter (0..RATE-1):
  - Advances only on cycles with inp_samp_str = 1.
  - When inp_samp_str = 1 and count == RATE-1: count wraps to 0 and inp_samp_data is captured into the decimated register.
  - dec_str is asserted high for exactly the following cycle.
  - Result: the first capture after reset is the RATE-th input strobe. RATE = 1 captures every strobe.
  - Samples without a strobe are ignored; the counter holds.
- Comb stage k (k = 1..STAGES), input = previous stage output and its strobe:
  - On input strobe: y_k <= x - d[M-1], d[0] <= x, d[1] <= d[0] (d[1] exists only when M = 2).
  - Stage strobe asserted the next cycle.
  - Delay lines update only on strobes.
  - Subtraction is in DATA_WIDTH_INP bits, wrap-around, no saturation.
- Output:
  - out_samp_data = final comb register[DATA_WIDTH_INP-1 -: DATA_WIDTH_OUT] (MSB truncation, no rounding).
  - out_samp_data holds its value between strobes.
- Latency: if the capturing input strobe is high in cycle t, out_samp_str is high in cycle t+STAGES+1 for exactly one cycle.
- Throughput:
  - The pipeline accepts an input strobe every cycle; no stalls and no backpressure.
  - Strobes spaced >= 1 cycle apart are all handled, including back-to-back.
  - The number of out_samp_str pulses equals floor(input strobes since reset / RATE).
- Simultaneous capture and output in the same cycle is legal; the stages are independent registers.

Test Plan:
- Ramp, N=1, M=1, R=4: inp_samp_data = 5k on the k-th strobe (k = 1, 2, ...) -> outputs 20, 20, 20, ...; first output 20 because the delay line starts at 0.
- Constant decimated input 7, N=3, M=1, R=1, widths 32/32 -> outputs 7, -14, 7, 0, 0, ...
- Wrap, N=1, M=1, R=1, widths 8/8: decimated samples 120 then -126 -> outputs 120 then 10 (modular difference). No saturation anywhere.
- Strobe timing, N=3, R=4: inp_samp_str pulsed every 3rd cycle for 20 strobes -> exactly 5 out_samp_str pulses. Each is one cycle wide and occurs 4 cycles after the 4th, 8th, ... input strobe. Repeat with strobes every cycle -> same counts and latency.
- Reset mid-operation, N=1, R=4: 2 strobes, pulse reset_n low asynchronously mid-cycle -> out_samp_data = 0 and out_samp_str = 0 immediately. After release, no output until 4 new strobes; the first output equals the 4th new sample.
- M=2, N=1, R=1: decimated samples 10, 20, 30, 40 -> outputs 10, 20, 20, 20.
